// File: rtl/prio_encoder8_3_seq.sv
// rtl/prio_encoder8_3_seq.sv - clocked 8-to-3 priority encoder with sticky pending and valid/ack handshake
// Optional duplicate-request overflow flag enabled by defining PRIO_ENC_OVERFLOW_EN.
module prio_encoder8_3_seq #(
  parameter int W = 3,
  parameter int N = 2**W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   En,
  input  logic [N-1:0] I,
  input  logic         ack,
`ifdef PRIO_ENC_OVERFLOW_EN
  input  logic         ovf_clr,
  output logic         ovf,
`endif
  output logic [W-1:0] Y,
  output logic         valid,
  output logic [N-1:0] pend,
  output logic         idle
);

  typedef enum logic {S_IDLE = 1'b0, S_PRESENT = 1'b1} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_y;
  logic [W-1:0] w_y_nxt;
  logic         r_valid;
  logic         w_valid_nxt;
  logic [N-1:0] r_pend;
  logic [N-1:0] w_pend_nxt;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_req;
  logic [W-1:0] w_hi;
  logic         w_en;

  assign w_en  = En[0] & ~En[1] & ~En[2];
  assign w_clr = (r_valid && ack) ? ({{(N-1){1'b0}}, 1'b1} << r_y) : '0;
  assign w_req = w_en ? I : '0;

  // A fresh request on the bit being cleared wins, so OR after masking.
  assign w_pend_nxt = (r_pend & ~w_clr) | w_req;

  always_comb begin
    w_hi = '0;
    for (int k = 0; k < N; k++) begin
      if (r_pend[k]) w_hi = W'(k);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_valid_nxt = r_valid;
    case (r_state)
      S_IDLE: begin
        if (w_en && (r_pend != '0)) begin
          w_y_nxt     = w_hi;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (ack) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_y     <= w_y_nxt;
      r_valid <= w_valid_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

`ifdef PRIO_ENC_OVERFLOW_EN
  logic r_ovf;
  logic w_dup;

  assign w_dup = |(w_req & r_pend & ~w_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_dup) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`endif

  assign Y     = r_y;
  assign valid = r_valid;
  assign pend  = r_pend;
  assign idle  = w_en & ~rst & (r_pend == '0) & ~r_valid;

endmodule

// File: tb/tb_prio_encoder8_3_seq.sv
// tb/tb_prio_encoder8_3_seq.sv - table-driven bench for prio_encoder8_3_seq
module tb_prio_encoder8_3_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] En;
  logic [7:0] I;
  logic       ack;
  logic [2:0] Y;
  logic       valid;
  logic [7:0] pend;
  logic       idle;
`ifdef PRIO_ENC_OVERFLOW_EN
  logic       ovf_clr;
  logic       ovf;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prio_encoder8_3_seq dut (
    .clk   (clk),
    .rst   (rst),
    .En    (En),
    .I     (I),
    .ack   (ack),
`ifdef PRIO_ENC_OVERFLOW_EN
    .ovf_clr (ovf_clr),
    .ovf     (ovf),
`endif
    .Y     (Y),
    .valid (valid),
    .pend  (pend),
    .idle  (idle)
  );

  typedef struct {
    logic       rst;
    logic [2:0] en;
    logic [7:0] i;
    logic       ack;
    logic [7:0] pend;
    logic       valid;
    logic [2:0] y;
    logic       idle;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [2:0] e, input logic [7:0] ii, input logic a,
                     input logic [7:0] p, input logic v, input logic [2:0] yy, input logic id);
    vec_t t;
    t.rst = r; t.en = e; t.i = ii; t.ack = a;
    t.pend = p; t.valid = v; t.y = yy; t.idle = id;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_edge(input logic r, input logic [2:0] e, input logic [7:0] ii, input logic a);
    rst = r; En = e; I = ii; ack = a;
    @(posedge clk);
    #1;
  endtask

  int waited;
  int nvalid;
  logic prev_v;

  initial begin
    rst = 1'b1; En = 3'b000; I = 8'h00; ack = 1'b0;
`ifdef PRIO_ENC_OVERFLOW_EN
    ovf_clr = 1'b0;
`endif
    //   rst en      I      ack  pend   v  y  idle
    add(1, 3'b000, 8'h00, 0, 8'h00, 0, 0, 0);
    add(1, 3'b000, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 3'b000, 8'hFF, 0, 8'h00, 0, 0, 0);
    add(0, 3'b000, 8'hFF, 0, 8'h00, 0, 0, 0);
    add(0, 3'b000, 8'hFF, 0, 8'h00, 0, 0, 0);
    add(0, 3'b001, 8'h04, 0, 8'h04, 0, 0, 0);
    add(0, 3'b001, 8'h00, 0, 8'h04, 1, 2, 0);
    add(0, 3'b001, 8'h00, 1, 8'h00, 0, 2, 1);
    add(0, 3'b001, 8'h12, 0, 8'h12, 0, 2, 0);
    add(0, 3'b001, 8'h00, 0, 8'h12, 1, 4, 0);
    add(0, 3'b001, 8'h80, 0, 8'h92, 1, 4, 0);
    add(0, 3'b001, 8'h00, 1, 8'h82, 0, 4, 0);
    add(0, 3'b001, 8'h00, 0, 8'h82, 1, 7, 0);
    add(0, 3'b001, 8'h00, 1, 8'h02, 0, 7, 0);
    add(0, 3'b001, 8'h00, 0, 8'h02, 1, 1, 0);
    add(0, 3'b001, 8'h00, 1, 8'h00, 0, 1, 1);
    add(0, 3'b001, 8'h20, 0, 8'h20, 0, 1, 0);
    add(0, 3'b001, 8'h00, 0, 8'h20, 1, 5, 0);
    add(0, 3'b001, 8'h20, 1, 8'h20, 0, 5, 0);
    add(0, 3'b001, 8'h00, 0, 8'h20, 1, 5, 0);
    add(0, 3'b001, 8'h00, 1, 8'h00, 0, 5, 1);
    add(0, 3'b011, 8'hFF, 0, 8'h00, 0, 5, 0);
    add(0, 3'b101, 8'hFF, 0, 8'h00, 0, 5, 0);
    add(0, 3'b111, 8'hFF, 0, 8'h00, 0, 5, 0);
    add(0, 3'b001, 8'h48, 1, 8'h48, 0, 5, 0);
    add(0, 3'b001, 8'h00, 1, 8'h48, 1, 6, 0);
    add(0, 3'b000, 8'h01, 0, 8'h48, 1, 6, 0);
    add(0, 3'b000, 8'h00, 1, 8'h08, 0, 6, 0);
    add(0, 3'b000, 8'h00, 0, 8'h08, 0, 6, 0);
    add(0, 3'b001, 8'h00, 0, 8'h08, 1, 3, 0);
    add(1, 3'b001, 8'hFF, 1, 8'h00, 0, 0, 0);
    add(0, 3'b001, 8'h00, 0, 8'h00, 0, 0, 1);

    foreach (tbl[k]) begin
      drive_edge(tbl[k].rst, tbl[k].en, tbl[k].i, tbl[k].ack);
      check($sformatf("row%0d pend", k), int'(pend), int'(tbl[k].pend));
      check($sformatf("row%0d valid", k), int'(valid), int'(tbl[k].valid));
      check($sformatf("row%0d Y", k), int'(Y), int'(tbl[k].y));
      check($sformatf("row%0d idle", k), int'(idle), int'(tbl[k].idle));
    end

    // Two-cycle latency from request to presented code.
    drive_edge(0, 3'b001, 8'h10, 0);
    check("lat pend", int'(pend), 8'h10);
    check("lat valid0", int'(valid), 0);
    waited = 0;
    I = 8'h00;
    while (!valid && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    check("lat cycles", waited, 1);
    check("lat Y", int'(Y), 4);
    drive_edge(0, 3'b001, 8'h00, 1);
    check("lat idle", int'(idle), 1);

    // Continuous request with constant ack: at most one code per 2 cycles.
    drive_edge(0, 3'b001, 8'h01, 1);
    nvalid = 0;
    prev_v = valid;
    for (int c = 0; c < 6; c++) begin
      drive_edge(0, 3'b001, 8'h01, 1);
      if (valid) nvalid++;
      check($sformatf("thr gap%0d", c), int'(valid & prev_v), 0);
      prev_v = valid;
    end
    check("thr count", nvalid, 3);
    drive_edge(1, 3'b000, 8'h00, 0);
    check("thr reset pend", int'(pend), 0);

`ifdef PRIO_ENC_OVERFLOW_EN
    check("ovf reset", int'(ovf), 0);
    drive_edge(0, 3'b001, 8'h01, 0);
    check("ovf first", int'(ovf), 0);
    drive_edge(0, 3'b001, 8'h01, 0);
    check("ovf dup", int'(ovf), 1);
    ovf_clr = 1'b1;
    drive_edge(0, 3'b001, 8'h00, 0);
    check("ovf clr", int'(ovf), 0);
    drive_edge(0, 3'b001, 8'h01, 0);
    check("ovf set wins", int'(ovf), 1);
    ovf_clr = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_encoder8_3_seq.md
Name: prio_encoder8_3_seq

Overview:
- Clocked 8-to-3 priority encoder; the encode-side counterpart of the team's 3-to-8 decoder (decoder3_8).
- Captures request lines into a sticky pending register and presents the highest-index pending request as a 3-bit code.
- Each code is held with a valid/ack handshake until a consumer acknowledges it.
- Typical use: an interrupt/request concentrator whose code output feeds decoder3_8 to drive a one-hot grant.

Parameters:
- W, 3, code width; request width N = 2**W (default 8).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- En  input  3  enable group, 74x138 style. Block is enabled when En[0]=1, En[1]=0 and En[2]=0 (en = En[0] & ~En[1] & ~En[2]).
- I  input  N  request lines, active-high, level-sampled each cycle.
- ack  input  1  consumer accepts the presented code.
- Y  output  W  encoded index of the presented request.
- valid  output  1  Y holds a presented request.
- pend  output  N  current pending register (status).
- idle  output  1  en=1 and pend==0 and valid=0 (EO analogue).

Behaviour:
- Reset (rst=1 at a rising edge): pend=0, Y=0, valid=0, state IDLE, idle=0 in that cycle. Reset overrides ack and I. Reset mid-presentation drops the request without any acknowledge.
- Capture, every cycle with en=1: pend_next = (pend & ~clr) | I.
  - clr = one-hot of Y when valid=1 and ack=1; otherwise 0.
  - A new request on the bit being cleared in the same cycle wins, so the bit stays pending.
- Capture with en=0: I is ignored. pend keeps its value apart from the clr effect.
- State IDLE:
  - If en=1 and pend!=0 (registered value): Y <= index of the highest set bit (bit N-1 has highest priority), valid <= 1, go to PRESENT.
  - Otherwise remain in IDLE with valid=0; Y keeps its last value.
- State PRESENT:
  - Y and valid are held stable regardless of I, En or later higher-priority arrivals.
  - On ack=1: clear pend[Y], valid <= 0, go to IDLE.
  - There is always at least one cycle with valid=0 between consecutive codes, so max throughput is one code per 2 cycles.
- ack while valid=0 is ignored and has no effect on pend.
- Dropping en to 0 during PRESENT does not abort the presentation; it completes on ack. No new presentation starts while en=0.
- Latency: I asserted before edge k gives pend set after edge k, then valid=1 and Y valid after edge k+1 (2 cycles).
- Priority is evaluated on the registered pend only, never directly on I.
- All outputs are registered except idle, which is combinational from en, pend and valid.

Optional Feature:
- Macro: PRIO_ENC_OVERFLOW_EN.
- When defined:
  - Adds output ovf (1 bit) and input ovf_clr (1 bit).
  - ovf is set sticky when en=1 and I[j]=1 for some j whose pend[j] is already 1 and is not being cleared in that cycle (a lost duplicate request).
  - ovf_clr=1 clears ovf. If set and clear happen in the same cycle, set wins.
  - ovf resets to 0.
- When not defined: neither port exists and duplicate requests merge silently.

Test Plan:
- Reset and enable gating:
  - Assert rst for 2 cycles; expect pend=0, valid=0, Y=0.
  - Then En=3'b000, I=8'hFF for 3 cycles; expect pend=0, valid=0 (disabled).
- Basic encode:
  - En=3'b001, I=8'b0000_0100 for 1 cycle; expect pend=8'h04 after 1 edge, then valid=1, Y=3'd2 after the next edge.
  - ack=1 for 1 cycle; expect valid=0, pend=0, idle=1.
- Priority and hold:
  - With pend=8'h12 presented as Y=4, raise I=8'h80 while PRESENT. Expect Y to stay 4 until ack.
  - Then next presentation is Y=7, then Y=1; final pend=0.
- Same-cycle clear and re-request:
  - While Y=5 is presented, apply ack=1 and I=8'h20 in the same cycle.
  - Expect pend[5]=1 after the edge and Y=5 presented again 1 cycle later.
- Enable variants and mid-operation events:
  - En=3'b011 or 3'b101 behaves as disabled.
  - Drop en during PRESENT; expect Y held, ack still completes, no new valid until en=1.
  - Assert rst while valid=1; expect valid=0, pend=0 next cycle.
- Overflow (PRIO_ENC_OVERFLOW_EN defined):
  - Hold I=8'h01 for 2 cycles with no ack; expect ovf=1 on the second capture.
  - ovf_clr=1 returns ovf to 0.
  - ovf_clr=1 coincident with a new duplicate leaves ovf=1.
